// File: rtl/gmux_switch_ctrl.sv
// gmux_switch_ctrl: glitch-free source switch and quadrant enable/VLP sequencer for a global clock mux
module gmux_switch_ctrl #(
  parameter int NUM_SRC   = 2,
  parameter int SEL_W     = $clog2(NUM_SRC),
  parameter int NUM_QUAD  = 4,
  parameter int RST_SEL   = 0,
  parameter int DIS_WAIT  = 4,
  parameter int SET_WAIT  = 4,
  parameter int VLP_IDLE  = 16,
  parameter int WAKE_WAIT = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [SEL_W-1:0]    req_sel_i,
  input  logic [NUM_QUAD-1:0] req_qen_i,
  output logic                ack_o,
  output logic                err_o,
  output logic                busy_o,
  output logic [SEL_W-1:0]    ssel_o,
  output logic [NUM_QUAD-1:0] den_o,
  output logic [NUM_QUAD-1:0] dynen_o,
  output logic [NUM_QUAD-1:0] vlp_o
);
  localparam int MAXW = (DIS_WAIT > SET_WAIT) ? ((DIS_WAIT > WAKE_WAIT) ? DIS_WAIT : WAKE_WAIT)
                                              : ((SET_WAIT > WAKE_WAIT) ? SET_WAIT : WAKE_WAIT);
  localparam int CW = $clog2(MAXW + 1);
  localparam int VW = (VLP_IDLE > 0) ? $clog2(VLP_IDLE + 1) : 1;
  typedef enum logic [2:0] {IDLE, DRAIN, SWITCH, SETTLE, WAKE, ENABLE} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d, ssel_q, ssel_d;
  logic [NUM_QUAD-1:0] qen_q, qen_d, den_q, den_d, vlp_q, vlp_d, vlp_clr, vset, dynen_q, gq;
  logic                ack_q, ack_d, err_q, err_d, busy_q, ready_q, accept, go;
  logic [VW-1:0]       idle_q [NUM_QUAD];
  logic [VW-1:0]       idle_d [NUM_QUAD];
  assign accept = req_valid_i & ready_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    sel_d   = sel_q;
    qen_d   = qen_q;
    ssel_d  = ssel_q;
    den_d   = den_q;
    vlp_clr = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    go      = 1'b0;
    gq      = qen_q;
    case (state_q)
      IDLE: if (accept) begin
        if (int'(req_sel_i) >= NUM_SRC) err_d = 1'b1;
        else begin
          sel_d = req_sel_i;
          qen_d = req_qen_i;
          gq    = req_qen_i;
          if (req_sel_i != ssel_q) begin
            state_d = DRAIN;
            cnt_d   = CW'(DIS_WAIT - 1);
            den_d   = '0;
          end else go = 1'b1;
        end
      end
      DRAIN: if (cnt_q == '0) begin
        state_d = SWITCH;
        ssel_d  = sel_q;
      end
      SWITCH: begin
        state_d = SETTLE;
        cnt_d   = CW'(SET_WAIT - 1);
      end
      SETTLE: go = (cnt_q == '0);
      WAKE: if (cnt_q == '0) begin
        state_d = ENABLE;
        den_d   = qen_q;
        ack_d   = 1'b1;
      end
      ENABLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Shared exit of the same-source accept and the settle phase: wake sleeping targets first
    if (go && |(gq & vlp_q)) begin
      state_d = WAKE;
      cnt_d   = CW'(WAKE_WAIT - 1);
      vlp_clr = gq;
    end else if (go) begin
      state_d = ENABLE;
      den_d   = gq;
      ack_d   = 1'b1;
    end
  end
  always_comb begin
    vset = '0;
    for (int i = 0; i < NUM_QUAD; i++) begin
      idle_d[i] = den_q[i] ? '0 : ((idle_q[i] == VW'(VLP_IDLE)) ? idle_q[i] : idle_q[i] + 1'b1);
      vset[i]   = (VLP_IDLE != 0) && !den_q[i] && (idle_q[i] == VW'(VLP_IDLE - 1));
    end
    vlp_d = (vlp_q | vset) & ~vlp_clr;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      qen_q   <= '0;
      ssel_q  <= SEL_W'(RST_SEL);
      den_q   <= '0;
      vlp_q   <= '0;
      dynen_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      for (int i = 0; i < NUM_QUAD; i++) idle_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      qen_q   <= qen_d;
      ssel_q  <= ssel_d;
      den_q   <= den_d;
      vlp_q   <= vlp_d;
      dynen_q <= '1;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= state_d != IDLE;
      ready_q <= state_d == IDLE;
      for (int i = 0; i < NUM_QUAD; i++) idle_q[i] <= idle_d[i];
    end
  end
  assign req_ready_o = ready_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign ssel_o      = ssel_q;
  assign den_o       = den_q;
  assign dynen_o     = dynen_q;
  assign vlp_o       = vlp_q;
endmodule

// File: tb/tb_gmux_switch_ctrl.sv
// tb_gmux_switch_ctrl: directed and random requests checked against a per-request timeline model
module tb_gmux_switch_ctrl;
  localparam int D = 4, S = 4, W = 2, VI = 16;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] qen = '0;
  logic ready, ack, err, busy;
  logic [1:0] ssel;
  logic [3:0] den, dynen, vlp;
  int nerr = 0, nchk = 0;
  logic [1:0] m_ssel;
  logic [3:0] m_den, m_vlp, m_dynen;
  logic m_ack, m_err, m_busy, m_ready;
  int m_idle [4];
  int lat;
  always #5 clk = ~clk;
  gmux_switch_ctrl #(.NUM_SRC(3)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
    .req_sel_i(sel), .req_qen_i(qen), .ack_o(ack), .err_o(err), .busy_o(busy),
    .ssel_o(ssel), .den_o(den), .dynen_o(dynen), .vlp_o(vlp)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic edge_upd(input bit r);
    @(posedge clk);
    if (r) begin
      m_ssel = 2'd0; m_den = '0; m_vlp = '0; m_dynen = '0;
      m_ready = 1'b0; m_busy = 1'b0; m_ack = 1'b0; m_err = 1'b0;
      foreach (m_idle[i]) m_idle[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_den[i]) m_idle[i] = 0;
        else begin
          m_idle[i]++;
          if (m_idle[i] == VI) m_vlp[i] = 1'b1;
        end
      end
      m_dynen = 4'hf; m_ready = 1'b1; m_busy = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    end
  endtask
  task automatic check_all();
    #1;
    chk("ssel", 32'(ssel), 32'(m_ssel));
    chk("den", 32'(den), 32'(m_den));
    chk("vlp", 32'(vlp), 32'(m_vlp));
    chk("dynen", 32'(dynen), 32'(m_dynen));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("err", 32'(err), 32'(m_err));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ready", 32'(ready), 32'(m_ready));
  endtask
  task automatic idle_cyc(input int n);
    for (int k = 0; k < n; k++) begin
      valid = 1'b0; sel = 2'($urandom); qen = 4'($urandom);
      edge_upd(1'b0);
      check_all();
    end
  endtask
  task automatic run_req(input logic [1:0] s, input logic [3:0] q, input int abort, output int dlat);
    bit diff, wk;
    int tdec, ten;
    logic [3:0] vprev;
    dlat = 0;
    valid = 1'b1; sel = s; qen = q;
    if (s == 2'd3) begin
      edge_upd(1'b0);
      m_err = 1'b1;
      check_all();
      valid = 1'b0;
      edge_upd(1'b0);
      check_all();
      return;
    end
    diff = (s != m_ssel);
    tdec = diff ? D + S + 2 : 1;
    ten  = 1 << 30;
    for (int j = 1; j <= ten + 1; j++) begin
      vprev = m_vlp;
      edge_upd(1'b0);
      if (j == tdec) begin
        wk  = |(q & vprev);
        ten = wk ? tdec + W : tdec;
        if (wk) m_vlp = m_vlp & ~q;
      end
      if (diff && j == 1) m_den = '0;
      if (diff && j == D + 1) m_ssel = s;
      if (j == ten) begin m_den = q; m_ack = 1'b1; end
      if (j <= ten) begin m_busy = 1'b1; m_ready = 1'b0; end
      check_all();
      if (ack === 1'b1 && dlat == 0) dlat = j;
      if (j == abort) begin
        valid = 1'b0;
        rst = 1'b1;
        edge_upd(1'b1);
        check_all();
        rst = 1'b0;
        edge_upd(1'b0);
        check_all();
        return;
      end
      valid = (j < ten) ? 1'($urandom) : 1'b0;
      sel = 2'($urandom); qen = 4'($urandom);
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      edge_upd(1'b1);
      check_all();
    end
    rst = 1'b0;
    edge_upd(1'b0);
    check_all();
    run_req(2'd0, 4'b1111, 0, lat);
    chk("lat_same0", 32'(lat), 32'd1);
    run_req(2'd1, 4'b0101, 0, lat);
    chk("lat_switch", 32'(lat), 32'd10);
    run_req(2'd1, 4'b1111, 0, lat);
    chk("lat_same1", 32'(lat), 32'd1);
    run_req(2'd3, 4'b1010, 0, lat);
    run_req(2'd1, 4'b0000, 0, lat);
    idle_cyc(20);
    chk("vlp_full", 32'(vlp), 32'hf);
    run_req(2'd1, 4'b0001, 0, lat);
    chk("lat_wake", 32'(lat), 32'd3);
    run_req(2'd0, 4'b1111, 0, lat);
    run_req(2'd1, 4'b0101, 6, lat);
    chk("abort_noack", 32'(lat), 32'd0);
    run_req(2'd2, 4'b0011, 0, lat);
    chk("lat_after_rst", 32'(lat), 32'd10);
    for (int n = 0; n < 40; n++) begin
      idle_cyc($urandom_range(0, 24));
      run_req(2'($urandom_range(0, 3)), 4'($urandom), 0, lat);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
